// File: rtl/winograd_tile_scheduler.sv
// winograd_tile_scheduler: issues (tile,ch) windows to a fixed-latency Winograd PE,
// accumulates the per-channel 2x2 results and streams each finished tile out.
module winograd_tile_scheduler #(
   parameter int NUM_CH      = 4,
   parameter int CH_W        = 2,
   parameter int TILE_W      = 16,
   parameter int NOUT        = 4,
   parameter int OUT_W       = 29,
   parameter int ACC_W       = 32,
   parameter int PE_LATENCY  = 8,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [TILE_W-1:0]       cfg_num_tiles,
   output logic                    busy,
   output logic                    done,
   input  logic                    src_valid,
   output logic                    src_rd,
   output logic [TILE_W-1:0]       src_tile_idx,
   output logic [CH_W-1:0]         src_ch_idx,
   input  logic [NOUT*OUT_W-1:0]   pe_out,
   output logic [NOUT*ACC_W-1:0]   out_data,
   output logic [TILE_W-1:0]       out_tile_idx,
   output logic                    out_valid,
   input  logic                    out_ready
);
   localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUTPUT} state_t;
   state_t r_state, w_next;

   logic [HW-1:0]          r_hold;
   logic                   r_in_win;
   logic [CH_W-1:0]        r_ch;
   logic [TILE_W-1:0]      r_tile, r_num, r_out_idx;
   logic [PE_LATENCY-1:0]  r_tv, r_tf, r_tl;
   logic [NOUT*ACC_W-1:0]  r_acc, r_out_data, w_sum;
   logic                   r_out_valid, r_done;
   logic                   w_start, w_last_hold, w_last_ch, w_cap_last, w_hs, w_more;
   logic [TILE_W:0]        w_tile_nx;

   assign w_start     = (r_state == S_IDLE) && start;
   assign w_last_hold = src_rd && (r_hold == HW'(HOLD_CYCLES - 1));
   assign w_last_ch   = r_ch == CH_W'(NUM_CH - 1);
   assign w_cap_last  = r_tv[0] && r_tl[0];
   assign w_hs        = r_out_valid && out_ready;
   assign w_tile_nx   = {1'b0, r_tile} + (TILE_W+1)'(1);
   assign w_more      = w_tile_nx < {1'b0, r_num};

   // Token bit 0 is the one whose PE result is on pe_out this cycle
   for (genvar i = 0; i < NOUT; i++) begin : g_lane
      logic [ACC_W-1:0] w_ext;
      assign w_ext = {{(ACC_W-OUT_W){pe_out[i*OUT_W+OUT_W-1]}}, pe_out[i*OUT_W +: OUT_W]};
      assign w_sum[i*ACC_W +: ACC_W] = r_tf[0] ? w_ext : r_acc[i*ACC_W +: ACC_W] + w_ext;
   end

   always_ff @(posedge clk) begin
      r_state <= reset ? S_IDLE : w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = (start && cfg_num_tiles != '0) ? S_ISSUE : S_IDLE;
         S_ISSUE: w_next = (w_last_hold && w_last_ch) ? S_DRAIN : S_ISSUE;
         S_DRAIN: w_next = w_cap_last ? S_OUTPUT : S_DRAIN;
         default: w_next = w_hs ? (w_more ? S_ISSUE : S_IDLE) : S_OUTPUT;
      endcase
   end

   always_comb begin
      busy   = r_state != S_IDLE;
      src_rd = (r_state == S_ISSUE) && (r_in_win || src_valid);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold      <= '0;
         r_in_win    <= 1'b0;
         r_ch        <= '0;
         r_tile      <= '0;
         r_num       <= '0;
         r_tv        <= '0;
         r_tf        <= '0;
         r_tl        <= '0;
         r_acc       <= '0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_hold      <= w_last_hold ? '0 : src_rd ? r_hold + 1'b1 : r_hold;
         r_in_win    <= src_rd && !w_last_hold;
         r_ch        <= w_last_hold ? (w_last_ch ? '0 : r_ch + 1'b1) : r_ch;
         r_tile      <= w_start ? '0 : (w_hs && w_more) ? w_tile_nx[TILE_W-1:0] : r_tile;
         r_num       <= w_start ? cfg_num_tiles : r_num;
         r_tv        <= PE_LATENCY'({w_last_hold, r_tv} >> 1);
         r_tf        <= PE_LATENCY'({r_ch == '0, r_tf} >> 1);
         r_tl        <= PE_LATENCY'({w_last_ch, r_tl} >> 1);
         r_acc       <= r_tv[0] ? w_sum : r_acc;
         r_out_data  <= w_cap_last ? w_sum : r_out_data;
         r_out_idx   <= w_cap_last ? r_tile : r_out_idx;
         r_out_valid <= w_cap_last ? 1'b1 : w_hs ? 1'b0 : r_out_valid;
         r_done      <= (w_start && cfg_num_tiles == '0) || (w_hs && !w_more);
      end
   end

   assign src_tile_idx = r_tile;
   assign src_ch_idx   = r_ch;
   assign out_data     = r_out_data;
   assign out_tile_idx = r_out_idx;
   assign out_valid    = r_out_valid;
   assign done         = r_done;
endmodule

// File: tb/tb_winograd_tile_scheduler.sv
// tb_winograd_tile_scheduler: directed vectors for the tile scheduler with a
// fixed-latency PE model; instances with NUM_CH=4 and NUM_CH=1.
module tb_winograd_tile_scheduler;
   localparam int L = 8;
   localparam int H = 4;
   localparam logic [115:0] JUNK = {4{29'h0ABC_DE1}};

   logic clk = 1'b0, reset = 1'b1, start = 1'b0, src_valid = 1'b1, out_ready = 1'b1;
   logic [15:0] cfg = '0;

   logic busy4, done4, rd4, ov4, busy1, done1, rd1, ov1;
   logic [15:0] tile4, oidx4, tile1, oidx1;
   logic [1:0] ch4, ch1;
   logic [115:0] pe4, pe1;
   logic [127:0] data4, data1;

   always #5 clk = ~clk;

   winograd_tile_scheduler #(.NUM_CH(4)) dut4 (
      .clk(clk), .reset(reset), .start(start), .cfg_num_tiles(cfg), .busy(busy4), .done(done4),
      .src_valid(src_valid), .src_rd(rd4), .src_tile_idx(tile4), .src_ch_idx(ch4), .pe_out(pe4),
      .out_data(data4), .out_tile_idx(oidx4), .out_valid(ov4), .out_ready(out_ready));

   winograd_tile_scheduler #(.NUM_CH(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .cfg_num_tiles(cfg), .busy(busy1), .done(done1),
      .src_valid(src_valid), .src_rd(rd1), .src_tile_idx(tile1), .src_ch_idx(ch1), .pe_out(pe1),
      .out_data(data1), .out_tile_idx(oidx1), .out_valid(ov1), .out_ready(out_ready));

   logic signed [28:0] pv [4][4];
   int tests = 0, fails = 0;

   function automatic logic [115:0] lanes(input logic [15:0] t, input logic [1:0] c);
      logic [115:0] r;
      for (int l = 0; l < 4; l++) r[l*29 +: 29] = pv[c][l] + ((l == 2) ? 29'(t * 100) : 29'd0);
      return r;
   endfunction

   // PE model: only the last hold cycle of a window yields real data, L cycles later
   logic [115:0] p4 [L], p1 [L];
   int c4 = 0, c1 = 0;
   always @(posedge clk) begin
      p4[0] <= (rd4 && c4 == H-1) ? lanes(tile4, ch4) : JUNK;
      p1[0] <= (rd1 && c1 == H-1) ? lanes(tile1, ch1) : JUNK;
      for (int k = 1; k < L; k++) begin
         p4[k] <= p4[k-1];
         p1[k] <= p1[k-1];
      end
      if (reset) begin
         c4 <= 0;
         c1 <= 0;
      end else begin
         if (rd4) c4 <= (c4 == H-1) ? 0 : c4 + 1;
         if (rd1) c1 <= (c1 == H-1) ? 0 : c1 + 1;
      end
   end
   assign pe4 = p4[L-1];
   assign pe1 = p1[L-1];

   typedef struct {
      int nt; int gap; int rdy;
      logic [31:0] e0, e1, e2, e3;
      int st2;
   } vec_t;
   vec_t vt [4];

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic init_pv();
      for (int c = 0; c < 4; c++) begin
         pv[c][0] = 29'(10 * (c + 1));
         pv[c][1] = -29'sd7;
         pv[c][2] = 29'(c + 1);
         pv[c][3] = 29'h1000_0000;
      end
   endtask

   task automatic wait_idle(input string n);
      int k = 0;
      out_ready = 1'b1; src_valid = 1'b1; start = 1'b0;
      while ((busy4 || busy1) && k < 500) begin
         @(negedge clk); #1; k++;
      end
      chk({n, " idle"}, {62'd0, busy4, busy1}, 64'd0);
   endtask

   task automatic run4(input vec_t v, input int id);
      int cyc = 0, rd = 0, tot = 0, tk = 0, ov = 0, zeros = 0, bad_ch = 0, bad_tile = 0;
      int unstable = 0, rd_bp = 0, ndone = 0, last_rd = 0, post = 0, done_tk = -1, gap_left;
      logic done_busy = 1'b0;
      logic [127:0] hd, ex;
      logic [15:0] hi;
      string s;
      s = $sformatf("v%0d", id);
      gap_left = v.gap;
      @(negedge clk);
      cfg = 16'(v.nt); start = 1'b1; src_valid = 1'b1; out_ready = (v.rdy == 0);
      #1;
      while (cyc < 3000 && (ndone == 0 || post < 4)) begin
         @(negedge clk);
         start = 1'b0;
         src_valid = !(rd == 8 && gap_left > 0);
         if (!src_valid) gap_left--;
         out_ready = ov >= v.rdy;
         #1; cyc++;
         if (ndone > 0) post++;
         if (rd4) begin
            if (ch4 !== 2'(rd / H)) bad_ch++;
            if (tile4 !== 16'(tk)) bad_tile++;
            rd++; tot++;
            if (rd == 16) last_rd = cyc;
         end else if (rd > 0 && rd < 16) zeros++;
         if (ov4) begin
            if (ov == 0) begin
               chk({s, " latency"}, 64'(cyc - last_rd), 64'(L + 1));
               hd = data4; hi = oidx4;
            end else if (data4 !== hd || oidx4 !== hi) unstable++;
            if (rd4) rd_bp++;
            ov++;
            if (out_ready) begin
               ex = {v.e3, v.e2 + 32'(tk * v.st2), v.e1, v.e0};
               chk({s, " out_tile_idx"}, 64'(oidx4), 64'(tk));
               for (int l = 0; l < 4; l++)
                  chk($sformatf("%s t%0d lane%0d", s, tk, l), 64'(data4[l*32 +: 32]), 64'(ex[l*32 +: 32]));
               tk++; rd = 0; ov = 0;
            end
         end
         if (done4) begin
            ndone++; done_tk = tk; done_busy = busy4;
         end
      end
      chk({s, " done count"}, 64'(ndone), 64'd1);
      chk({s, " done after last"}, 64'(done_tk), 64'(v.nt));
      chk({s, " busy at done"}, 64'(done_busy), 64'd0);
      chk({s, " ch sequence"}, 64'(bad_ch), 64'd0);
      chk({s, " src tile"}, 64'(bad_tile), 64'd0);
      chk({s, " src_rd total"}, 64'(tot), 64'(16 * v.nt));
      chk({s, " src_rd gap"}, 64'(zeros), 64'(v.gap));
      chk({s, " out stable"}, 64'(unstable), 64'd0);
      chk({s, " src_rd in output"}, 64'(rd_bp), 64'd0);
      wait_idle(s);
   endtask

   task automatic run1();
      int cyc = 0, rd = 0, last = 0, seen = 0, nd = 0;
      logic [127:0] ex;
      ex = {32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFFD, 32'd5};
      @(negedge clk);
      cfg = 16'd1; start = 1'b1; out_ready = 1'b1; src_valid = 1'b1;
      #1;
      while (cyc < 300 && nd == 0) begin
         @(negedge clk); start = 1'b0; #1; cyc++;
         if (rd1) begin rd++; last = cyc; end
         if (ov1 && seen == 0) begin
            seen = 1;
            chk("n1 latency", 64'(cyc - last), 64'(L + 1));
            chk("n1 out_tile_idx", 64'(oidx1), 64'd0);
            for (int l = 0; l < 4; l++)
               chk($sformatf("n1 lane%0d", l), 64'(data1[l*32 +: 32]), 64'(ex[l*32 +: 32]));
         end
         if (done1) nd = 1;
      end
      chk("n1 src_rd count", 64'(rd), 64'(H));
      chk("n1 output seen", 64'(seen), 64'd1);
      chk("n1 done", 64'(nd), 64'd1);
      wait_idle("n1");
   endtask

   task automatic run_zero();
      int act = 0;
      @(negedge clk); cfg = 16'd0; start = 1'b1; #1;
      @(negedge clk); start = 1'b0; #1;
      chk("zero done4", 64'(done4), 64'd1);
      chk("zero done1", 64'(done1), 64'd1);
      chk("zero busy", {62'd0, busy4, busy1}, 64'd0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
         act += int'(rd4) + int'(ov4) + int'(done4) + int'(busy4) + int'(rd1) + int'(ov1);
      end
      chk("zero no activity", 64'(act), 64'd0);
   endtask

   task automatic run_reset();
      int k = 0, rd = 0, after = 0;
      @(negedge clk); cfg = 16'd1; start = 1'b1; #1;
      while (k < 300 && after < 3) begin
         @(negedge clk); start = 1'b0; #1; k++;
         if (rd4) rd++;
         if (rd == 16) after++;
      end
      chk("rst reached drain", 64'(rd), 64'd16);
      chk("rst no early out", 64'(ov4), 64'd0);
      @(negedge clk); reset = 1'b1; #1;
      @(negedge clk); reset = 1'b0; #1;
      chk("rst flags", {60'd0, busy4, done4, rd4, ov4}, 64'd0);
      chk("rst out_data", 64'(data4[63:0] | data4[127:64]), 64'd0);
      chk("rst idx", {30'd0, oidx4, tile4, ch4}, 64'd0);
   endtask

   initial begin
      init_pv();
      vt[0] = '{nt:1, gap:0, rdy:0,  e0:32'd100, e1:32'hFFFF_FFE4, e2:32'd10, e3:32'hC000_0000, st2:400};
      vt[1] = '{nt:1, gap:5, rdy:0,  e0:32'd100, e1:32'hFFFF_FFE4, e2:32'd10, e3:32'hC000_0000, st2:400};
      vt[2] = '{nt:2, gap:0, rdy:20, e0:32'd100, e1:32'hFFFF_FFE4, e2:32'd10, e3:32'hC000_0000, st2:400};
      vt[3] = '{nt:3, gap:0, rdy:0,  e0:32'd100, e1:32'hFFFF_FFE4, e2:32'd10, e3:32'hC000_0000, st2:400};
      repeat (3) @(negedge clk);
      reset = 1'b0; #1;
      chk("reset flags", {60'd0, busy4, done4, rd4, ov4}, 64'd0);
      chk("reset out_data", 64'(data4[63:0] | data4[127:64]), 64'd0);
      chk("reset idx", {30'd0, oidx4, tile4, ch4}, 64'd0);
      pv[0][0] = 29'sd5; pv[0][1] = -29'sd3; pv[0][2] = 29'sd100; pv[0][3] = -29'sd1;
      run1();
      init_pv();
      run_zero();
      for (int i = 0; i < 4; i++) run4(vt[i], i);
      run_reset();
      run4(vt[0], 9);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
